fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Fetch sequencer for the PC / instruction-memory path. It owns the PC register, drives the combinational instruction ROM address, and delivers fetched words to decode through a one-entry valid/ready output register. It applies branch redirection (pc_src, imm_op) and stalls on downstream backpressure. While halted it shares the ROM address port with a debug read port.

Parameters:
ADDRESS_WIDTH, 8, PC / ROM address width in bits.
DATA_WIDTH, 32, instruction word width.
RESET_PC, 0, PC value loaded on reset.
CNT_WIDTH, 16, width of the fetch counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; synchronous, active-low (0 = reset).
pc_src  in  1  branch select from the control unit; sampled only on a fetch fire.
imm_op  in  ADDRESS_WIDTH  branch offset from sign-extend.
halt_req  in  1  level request to stop fetching.
instr_ready  in  1  decode can accept instr.
mem_addr  out  ADDRESS_WIDTH  ROM address (combinational).
mem_rd  in  DATA_WIDTH  ROM read data for mem_addr, same cycle.
instr  out  DATA_WIDTH  fetched word (registered).
instr_pc  out  ADDRESS_WIDTH  address of instr (registered).
instr_valid  out  1  instr / instr_pc hold a word for decode.
halted  out  1  high while in the HALTED state.
dbg_req  in  1  debug read request; honoured only in HALTED.
dbg_addr  in  ADDRESS_WIDTH  debug read address.
dbg_rvalid  out  1  one-cycle pulse when dbg_rdata updates.
dbg_rdata  out  DATA_WIDTH  captured debug read data.
fetch_cnt  out  CNT_WIDTH  count of fetch fires; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst=0 at an edge):
  - pc=RESET_PC; instr=0; instr_pc=0; instr_valid=0.
  - halted=0; dbg_rvalid=0; dbg_rdata=0; fetch_cnt=0; state=BOOT.
  - Reset mid-operation discards any held word and any pending debug read.
- FSM states: BOOT, RUN, HALTED.
  - BOOT lasts exactly one cycle after reset release and performs no fetch.
  - From BOOT: go to HALTED if halt_req=1, else RUN.
- mem_addr:
  - pc in BOOT and RUN.
  - dbg_addr in HALTED.
- Fetch fire (RUN only): condition is halt_req=0 and (instr_valid=0 or instr_ready=1). On fire:
  - instr<=mem_rd; instr_pc<=pc; instr_valid<=1; fetch_cnt<=fetch_cnt+1.
  - pc<=pc_src ? pc+imm_op : pc+4, truncated to ADDRESS_WIDTH (wraps).
- Stall: no fire in RUN leaves pc, instr and instr_pc unchanged. pc_src and imm_op are ignored.
- Output handshake: a word transfers when instr_valid && instr_ready.
  - Outside RUN (or halt_req=1 in RUN), a transfer clears instr_valid to 0.
  - Without a transfer, instr_valid holds.
  - instr and instr_pc never change while instr_valid=1 && instr_ready=0.
- Halt:
  - halt_req=1 in RUN: move to HALTED at the next edge; no fire that cycle (halt beats fetch).
  - halted=1 from the following cycle. pc is preserved.
  - In HALTED with halt_req=0: go to RUN next edge; fetching resumes from the preserved pc.
- Debug read:
  - In HALTED with dbg_req=1: dbg_rdata<=mem_rd (data at dbg_addr), dbg_rvalid=1 the next cycle.
  - dbg_rvalid is 0 in every other cycle.
  - dbg_req in BOOT or RUN is ignored; dbg_rdata holds.
- Simultaneous events:
  - dbg_req and halt_req falling in the same HALTED cycle: the debug read is still serviced, then the block moves to RUN.

Test Plan:
1. RESET_PC=0, ROM word = 0xA000_0000+addr, instr_ready=1, pc_src=0; release reset -> BOOT cycle with instr_valid=0; then instr_pc=0x00,0x04,0x08 on successive cycles, instr matches, fetch_cnt=1,2,3.
2. instr_ready=0 for 3 cycles while instr_pc=0x08 -> instr/instr_pc hold, mem_addr=0x0C, fetch_cnt frozen; ready=1 -> next instr_pc=0x0C.
3. Branch: fire at pc=0x08 with pc_src=1, imm_op=0x10 -> following instr_pc=0x18. Wrap: pc=0xFC, pc_src=0 -> next instr_pc=0x00.
4. Halt and debug:
   - halt_req=1 at pc=0x20 -> no fire that cycle, halted=1 the next cycle; with ready=1, instr_valid drops.
   - dbg_req=1, dbg_addr=0x40 -> one-cycle dbg_rvalid with dbg_rdata=0xA000_0040.
   - halt_req=0 -> fetching resumes with instr_pc=0x20.
5. dbg_req=1 during RUN -> dbg_rvalid stays 0, mem_addr remains pc.
6. Reset mid-stall (instr_valid=1, ready=0, pc=0x30) -> after reset pc=0, instr_valid=0, fetch_cnt=0, BOOT repeated.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch sequencer's decode, ROM and debug signals.
// master is the fetch_ctrl side, slave is the surrounding pipeline/ROM/debugger.
interface fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) ();
  logic                     pc_src;
  logic [ADDRESS_WIDTH-1:0] imm_op;
  logic                     halt_req;
  logic                     instr_ready;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_rd;
  logic [DATA_WIDTH-1:0]    instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic                     instr_valid;
  logic                     halted;
  logic                     dbg_req;
  logic [ADDRESS_WIDTH-1:0] dbg_addr;
  logic                     dbg_rvalid;
  logic [DATA_WIDTH-1:0]    dbg_rdata;
  logic [CNT_WIDTH-1:0]     fetch_cnt;

  modport master (
    input  pc_src, imm_op, halt_req, instr_ready, mem_rd, dbg_req, dbg_addr,
    output mem_addr, instr, instr_pc, instr_valid, halted, dbg_rvalid, dbg_rdata, fetch_cnt
  );

  modport slave (
    output pc_src, imm_op, halt_req, instr_ready, mem_rd, dbg_req, dbg_addr,
    input  mem_addr, instr, instr_pc, instr_valid, halted, dbg_rvalid, dbg_rdata, fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address, and hands fetched
// words to decode through a one-entry valid/ready register; shares the ROM with debug while halted.
module fetch_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int RESET_PC      = 0,
  parameter int CNT_WIDTH     = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q;
  logic                     instr_valid_q;
  logic                     halted_q;
  logic                     dbg_rvalid_q;
  logic [DATA_WIDTH-1:0]    dbg_rdata_q;
  logic [CNT_WIDTH-1:0]     cnt_q;

  logic                     xfer;
  logic                     fire;
  logic [ADDRESS_WIDTH-1:0] pc_next;

  assign xfer    = instr_valid_q & bus.instr_ready;
  // Halt beats fetch: a pending halt_req suppresses the fire in RUN.
  assign fire    = (state == RUN) & ~bus.halt_req & (~instr_valid_q | bus.instr_ready);
  assign pc_next = bus.pc_src ? pc + bus.imm_op : pc + ADDRESS_WIDTH'(4);

  assign bus.mem_addr    = (state == HALTED) ? bus.dbg_addr : pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.fetch_cnt   = cnt_q;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= BOOT;
      pc            <= ADDRESS_WIDTH'(RESET_PC);
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      dbg_rdata_q   <= '0;
      cnt_q         <= '0;
    end else begin
      dbg_rvalid_q <= 1'b0;
      case (state)
        BOOT: begin
          if (bus.halt_req) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.halt_req) begin
            state    <= HALTED;
            halted_q <= 1'b1;
            if (xfer) instr_valid_q <= 1'b0;
          end else if (fire) begin
            instr_q       <= bus.mem_rd;
            instr_pc_q    <= pc;
            instr_valid_q <= 1'b1;
            cnt_q         <= cnt_q + CNT_WIDTH'(1);
            pc            <= pc_next;
          end
        end
        HALTED: begin
          // mem_addr is dbg_addr here, so mem_rd is the debug word.
          if (bus.dbg_req) begin
            dbg_rdata_q  <= bus.mem_rd;
            dbg_rvalid_q <= 1'b1;
          end
          if (xfer) instr_valid_q <= 1'b0;
          if (!bus.halt_req) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
